snes_frame_queue: RTL and testbench

Upstream feeder for the 3-line (S)NES controller emulator: buffers host-supplied controller frames (three 32-bit words, one per data line) and presents exactly one frame on `data0..data2` per console latch. Each pulse on the console `lat` line consumes one frame. The shift-register stage samples `data0..data2` on `lat`, so this block advances on the latch falling edge, after the current frame has been captured. Host writes arrive through a valid/ready handshake on the system clock.

---
 rtl/snes_frame_queue_pkg.sv | 20 ++
 rtl/snes_frame_queue_if.sv | 24 ++
 rtl/snes_frame_queue_fifo.sv | 72 +++++++
 rtl/snes_frame_queue.sv | 133 +++++++++++++
 tb/tb_snes_frame_queue.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snes_frame_queue_pkg.sv
// Shared types for the controller frame queue: frame layout, idle pattern, FSM states.
package snes_pkg;

    localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] w2;
        logic [31:0] w1;
        logic [31:0] w0;
    } frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Buttons are active-low, so all-ones means nothing pressed on any line.
    localparam frame_t IDLE_FRAME = '{w2: IDLE_WORD, w1: IDLE_WORD, w0: IDLE_WORD};

endpackage

// File: rtl/snes_frame_queue_if.sv
// Host-side frame write channel: one 96-bit frame per valid/ready handshake.
interface snes_frame_queue_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data0;
    logic [31:0] wr_data1;
    logic [31:0] wr_data2;

    modport master (
        output wr_valid,
        output wr_data0,
        output wr_data1,
        output wr_data2,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data0,
        input  wr_data1,
        input  wr_data2,
        output wr_ready
    );
endinterface

// File: rtl/snes_frame_queue_fifo.sv
// Purpose: DEPTH x 96-bit synchronous frame FIFO with flush.
// Latency: pushed frame visible at rd_frame the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; no bypass.
module frame_fifo
    import snes_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  frame_t                 wr_frame,
    output frame_t                 rd_frame,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    frame_t        mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_frame = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_frame;
    end

endmodule

// File: rtl/snes_frame_queue.sv
// Purpose: buffers host controller frames and presents one per console latch.
// Latency: lat_in fall to new data is SYNC_STAGES+2 clk; arm start is 1 clk.
// Backpressure: wr_ready low when FIFO full or during flush; refused writes drop.
module snes_frame_queue
    import snes_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   flush,
    snes_frame_queue_if.slave      wr,
    input  logic                   lat_in,
    output logic [31:0]            data0,
    output logic [31:0]            data1,
    output logic [31:0]            data2,
    output logic [$clog2(DEPTH):0] level,
    output logic                   running,
    output logic                   underflow,
    output logic [15:0]            underflow_cnt
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lat_prev_q, lat_prev_d;
    logic                   lat_fall_q, lat_fall_d;
    state_t                 state_q, state_d;
    frame_t                 data_q, data_d;
    logic                   underflow_q, underflow_d;
    logic [15:0]            ucnt_q, ucnt_d;

    frame_t                 wr_frame;
    frame_t                 head;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign wr_frame    = '{w2: wr.wr_data2, w1: wr.wr_data1, w0: wr.wr_data0};
    assign wr.wr_ready = !fifo_full && !flush;
    assign push        = wr.wr_valid && wr.wr_ready;

    frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_frame (wr_frame),
        .rd_frame (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    // The flag is registered so the controller stage has already captured the
    // outgoing frame on lat before we replace it.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], lat_in};
        lat_prev_d = sync_q[SYNC_STAGES-1];
        lat_fall_d = lat_prev_q && !sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        underflow_d = underflow_q;
        ucnt_d      = ucnt_q;
        pop         = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            data_d      = IDLE_FRAME;
            underflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm && !fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = head;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!arm) begin
                        state_d = IDLE;
                        data_d  = IDLE_FRAME;
                    end else if (lat_fall_q) begin
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            data_d = head;
                        end else begin
                            data_d      = IDLE_FRAME;
                            underflow_d = 1'b1;
                            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    data_d  = IDLE_FRAME;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            lat_prev_q  <= 1'b0;
            lat_fall_q  <= 1'b0;
            state_q     <= IDLE;
            data_q      <= IDLE_FRAME;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            lat_prev_q  <= lat_prev_d;
            lat_fall_q  <= lat_fall_d;
            state_q     <= state_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign data0         = data_q.w0;
    assign data1         = data_q.w1;
    assign data2         = data_q.w2;
    assign running       = (state_q == RUN);
    assign underflow     = underflow_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_snes_frame_queue.sv
// Directed bench for snes_frame_queue: queue-level model compared every cycle plus literal spot checks.
module tb_snes_frame_queue;
    import snes_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SYNC  = 2;
    localparam logic [31:0] IW    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        arm = 1'b0;
    logic        flush = 1'b0;
    logic        lat_in = 1'b0;
    logic [31:0] data0, data1, data2;
    logic [4:0]  level;
    logic        running, underflow;
    logic [15:0] underflow_cnt;

    int checks = 0;
    int errors = 0;

    snes_frame_queue_if wr_if ();

    snes_frame_queue #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .flush         (flush),
        .wr            (wr_if),
        .lat_in        (lat_in),
        .data0         (data0),
        .data1         (data1),
        .data2         (data2),
        .level         (level),
        .running       (running),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    frame_t      m_q[$];
    frame_t      m_pres = '{w2: IW, w1: IW, w0: IW};
    bit          m_run = 0;
    bit          m_uf = 0;
    int          m_cnt = 0;
    bit          m_hist [SYNC+3];

    function automatic frame_t mkf(input int n);
        frame_t f;
        f.w0 = 32'hA000_0000 | n;
        f.w1 = 32'hB000_0000 | n;
        f.w2 = 32'hC000_0000 | n;
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pres = '{w2: IW, w1: IW, w0: IW};
            m_run  = 0;
            m_uf   = 0;
            m_cnt  = 0;
            for (int i = 0; i < SYNC + 3; i++) m_hist[i] = 0;
        end else begin
            bit     fall;
            bit     do_pop;
            bit     do_push;
            frame_t wf;
            for (int i = SYNC + 2; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = lat_in;
            // A fall sampled at edge j takes effect at edge j+SYNC+1.
            fall    = !m_hist[SYNC+1] && m_hist[SYNC+2];
            do_push = wr_if.wr_valid && (m_q.size() < DEPTH) && !flush;
            wf      = '{w2: wr_if.wr_data2, w1: wr_if.wr_data1, w0: wr_if.wr_data0};
            do_pop  = 0;
            if (flush) begin
                m_q.delete();
                m_run  = 0;
                m_uf   = 0;
                m_pres = '{w2: IW, w1: IW, w0: IW};
                do_push = 0;
            end else if (!m_run) begin
                if (arm && m_q.size() != 0) begin
                    m_pres = m_q[0];
                    do_pop = 1;
                    m_run  = 1;
                end
            end else if (!arm) begin
                m_run  = 0;
                m_pres = '{w2: IW, w1: IW, w0: IW};
            end else if (fall) begin
                if (m_q.size() != 0) begin
                    m_pres = m_q[0];
                    do_pop = 1;
                end else begin
                    m_pres = '{w2: IW, w1: IW, w0: IW};
                    m_uf   = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(wf);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("data0", data0, m_pres.w0);
        chk("data1", data1, m_pres.w1);
        chk("data2", data2, m_pres.w2);
        chk("level", 32'(level), 32'(m_q.size()));
        chk("running", 32'(running), 32'(m_run));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
        chk("wr_ready", 32'(wr_if.wr_ready), 32'((m_q.size() < DEPTH) && !flush));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input frame_t f);
        wr_if.wr_data0 = f.w0;
        wr_if.wr_data1 = f.w1;
        wr_if.wr_data2 = f.w2;
    endtask

    task automatic push_frame(input frame_t f);
        drive(f);
        wr_if.wr_valid = 1'b1;
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    // Returns SYNC+2 edges after the fall, i.e. once the new frame is presented.
    task automatic pulse_lat(input bit do_push, input frame_t f, input bit do_flush);
        lat_in = 1'b1;
        repeat (SYNC + 1) tick();
        lat_in = 1'b0;
        repeat (SYNC + 1) tick();
        if (do_push) begin
            drive(f);
            wr_if.wr_valid = 1'b1;
        end
        flush = do_flush;
        tick();
        wr_if.wr_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t fa, fb;
        fa = '{w2: 32'h0000_0003, w1: 32'h0000_0002, w0: 32'h0000_0001};
        fb = mkf(2);
        wr_if.wr_valid = 1'b0;
        drive(mkf(0));
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_data0", data0, IW);
        chk("rst_data2", data2, IW);
        chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: start playback, then one latch
        push_frame(fa);
        push_frame(fb);
        arm = 1'b1;
        tick();
        chk("t1_data0", data0, 32'h0000_0001);
        chk("t1_data1", data1, 32'h0000_0002);
        chk("t1_data2", data2, 32'h0000_0003);
        chk("t1_level", 32'(level), 32'd1);
        lat_in = 1'b1;
        repeat (SYNC + 1) tick();
        lat_in = 1'b0;
        repeat (SYNC + 1) tick();
        chk("t1_hold_a", data0, 32'h0000_0001);
        tick();
        chk("t1_b_w0", data0, 32'hA000_0002);
        chk("t1_b_w2", data2, 32'hC000_0002);

        // 2: fill to full, drop a write, drain one
        arm = 1'b0;
        do_flush();
        push_frame(mkf(199));
        arm = 1'b1;
        tick();
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(mkf(200 + i));
            tick();
        end
        chk("t2_full_rdy", 32'(wr_if.wr_ready), 32'd0);
        chk("t2_full_lvl", 32'(level), 32'd16);
        drive(mkf(999));
        tick();
        wr_if.wr_valid = 1'b0;
        chk("t2_drop_lvl", 32'(level), 32'd16);
        pulse_lat(0, mkf(0), 0);
        chk("t2_lvl15", 32'(level), 32'd15);
        chk("t2_rdy1", 32'(wr_if.wr_ready), 32'd1);
        chk("t2_head", data0, 32'hA000_00C8);

        // 3: underflow on an empty FIFO
        do_flush();
        push_frame(mkf(300));
        tick();
        chk("t3_run", 32'(running), 32'd1);
        for (int i = 0; i < 3; i++) pulse_lat(0, mkf(0), 0);
        chk("t3_idle_w", data1, IW);
        chk("t3_uf", 32'(underflow), 32'd1);
        chk("t3_ucnt", 32'(underflow_cnt), 32'd3);
        push_frame(mkf(301));
        pulse_lat(0, mkf(0), 0);
        chk("t3_c", data0, 32'hA000_012D);

        // 4: flush collides with a write and a latch
        push_frame(mkf(310));
        push_frame(mkf(311));
        pulse_lat(1, mkf(312), 1);
        chk("t4_lvl", 32'(level), 32'd0);
        chk("t4_idle", 32'(running), 32'd0);
        chk("t4_data", data0, IW);
        chk("t4_ucnt", 32'(underflow_cnt), 32'd3);
        chk("t4_uf", 32'(underflow), 32'd0);
        arm = 1'b0;
        tick();

        // 5: reset mid-playback
        for (int i = 0; i < 6; i++) push_frame(mkf(320 + i));
        arm = 1'b1;
        tick();
        chk("t5_lvl5", 32'(level), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_data", data0, IW);
        chk("t5_async_lvl", 32'(level), 32'd0);
        chk("t5_async_run", 32'(running), 32'd0);
        chk("t5_async_ucnt", 32'(underflow_cnt), 32'd0);
        arm = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_lat(0, mkf(0), 0);
        chk("t5_nolat", data0, IW);
        push_frame(mkf(400));
        pulse_lat(0, mkf(0), 0);
        chk("t5_nolat2", data0, IW);
        chk("t5_lvl1", 32'(level), 32'd1);
        arm = 1'b1;
        tick();
        chk("t5_rearm", data0, 32'hA000_0190);

        // 6: push and pop together, across pointer wrap
        arm = 1'b0;
        do_flush();
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(mkf(100 + i));
            tick();
        end
        wr_if.wr_valid = 1'b0;
        arm = 1'b1;
        tick();
        chk("t6_first", data0, 32'hA000_0064);
        pulse_lat(1, mkf(105), 0);
        chk("t6_lvl4", 32'(level), 32'd4);
        chk("t6_head", data2, 32'hC000_0065);
        for (int k = 1; k <= 20; k++) pulse_lat(1, mkf(105 + k), 0);
        chk("t6_wrap", data0, 32'hA000_0079);
        chk("t6_lvl_end", 32'(level), 32'd4);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
